// File: rtl/avl_stream_mux3_rr.sv
// avl_stream_mux3_rr
//   Packet-atomic, round-robin 3-to-1 Avalon-ST multiplexer. Merges three
//   producer streams into one consumer stream and stamps out_channel with
//   the index of the source input so downstream stages can demultiplex.
//
// Ports
//   clk, rst          single clock; synchronous active-high reset
//   inK_data/valid/sop/eop/empty   input stream K (K = 0..2)
//   inK_ready         mux accepts the beat on inK this cycle (ready latency 0)
//   inK_almost_full   copy of out_almost_full
//   out_data/valid/sop/eop/empty/channel   merged stream (one-entry register)
//   out_ready         consumer back-pressure
//   out_almost_full   consumer fill hint, fanned back to every input
//   sop_err           sticky: a packet started on a beat without sop
module avl_stream_mux3_rr #(
    parameter  int WIDTH   = 512,
    parameter  int MAX_CH  = 4,
    parameter  int CH_MIN  = 4,
    localparam int EMPTY_W = $clog2(WIDTH / 8),
    localparam int CH_W    = $clog2((MAX_CH > CH_MIN) ? MAX_CH : CH_MIN)
) (
    input  logic               clk,
    input  logic               rst,

    input  logic [WIDTH-1:0]   in0_data,
    input  logic               in0_valid,
    input  logic               in0_sop,
    input  logic               in0_eop,
    input  logic [EMPTY_W-1:0] in0_empty,
    output logic               in0_ready,
    output logic               in0_almost_full,

    input  logic [WIDTH-1:0]   in1_data,
    input  logic               in1_valid,
    input  logic               in1_sop,
    input  logic               in1_eop,
    input  logic [EMPTY_W-1:0] in1_empty,
    output logic               in1_ready,
    output logic               in1_almost_full,

    input  logic [WIDTH-1:0]   in2_data,
    input  logic               in2_valid,
    input  logic               in2_sop,
    input  logic               in2_eop,
    input  logic [EMPTY_W-1:0] in2_empty,
    output logic               in2_ready,
    output logic               in2_almost_full,

    output logic [WIDTH-1:0]   out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_sop,
    output logic               out_eop,
    output logic [EMPTY_W-1:0] out_empty,
    output logic [CH_W-1:0]    out_channel,
    input  logic               out_almost_full,

    output logic               sop_err
);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t state;
    logic [1:0] gnt;
    logic [1:0] ptr;

    logic [1:0] sel;
    logic       sel_ok;
    logic [1:0] idx;
    logic [3:0] vld;
    logic       can_accept;
    logic       grant;
    logic       take;

    logic [WIDTH-1:0]   s_data;
    logic               s_sop;
    logic               s_eop;
    logic [EMPTY_W-1:0] s_empty;

    function automatic logic [1:0] inc3(input logic [1:0] x);
        return (x == 2'd2) ? 2'd0 : x + 2'd1;
    endfunction

    // Bit 3 is a constant 0 so a 2-bit index never selects outside the vector.
    assign vld = {1'b0, in2_valid, in1_valid, in0_valid};

    // While LOCKED the granted input is selected whether or not it is valid,
    // so its ready follows out_can_accept alone.
    always_comb begin
        sel    = gnt;
        sel_ok = 1'b0;
        idx    = ptr;
        if (state == LOCKED) begin
            sel_ok = 1'b1;
        end else begin
            for (int unsigned i = 0; i < 3; i++) begin
                if (!sel_ok && vld[idx]) begin
                    sel    = idx;
                    sel_ok = 1'b1;
                end
                idx = inc3(idx);
            end
        end
    end

    always_comb begin
        case (sel)
            2'd1: begin
                s_data  = in1_data;
                s_sop   = in1_sop;
                s_eop   = in1_eop;
                s_empty = in1_empty;
            end
            2'd2: begin
                s_data  = in2_data;
                s_sop   = in2_sop;
                s_eop   = in2_eop;
                s_empty = in2_empty;
            end
            default: begin
                s_data  = in0_data;
                s_sop   = in0_sop;
                s_eop   = in0_eop;
                s_empty = in0_empty;
            end
        endcase
    end

    assign can_accept = !out_valid || out_ready;
    assign grant      = sel_ok && can_accept && !rst;
    assign take       = grant && vld[sel];

    assign in0_ready = grant && (sel == 2'd0);
    assign in1_ready = grant && (sel == 2'd1);
    assign in2_ready = grant && (sel == 2'd2);

    assign in0_almost_full = out_almost_full;
    assign in1_almost_full = out_almost_full;
    assign in2_almost_full = out_almost_full;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            gnt         <= 2'd0;
            ptr         <= 2'd0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_sop     <= 1'b0;
            out_eop     <= 1'b0;
            out_empty   <= '0;
            out_channel <= '0;
            sop_err     <= 1'b0;
        end else begin
            if (take) begin
                out_valid   <= 1'b1;
                out_data    <= s_data;
                out_sop     <= s_sop;
                out_eop     <= s_eop;
                out_empty   <= s_empty;
                out_channel <= CH_W'(sel);
                if (state == IDLE) begin
                    // Any beat accepted in IDLE starts a packet, sop or not.
                    if (!s_sop) begin
                        sop_err <= 1'b1;
                    end
                    if (s_eop) begin
                        ptr <= inc3(sel);
                    end else begin
                        state <= LOCKED;
                        gnt   <= sel;
                    end
                end else if (s_eop) begin
                    state <= IDLE;
                    ptr   <= inc3(gnt);
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_avl_stream_mux3_rr.sv
// tb_avl_stream_mux3_rr
//   Scoreboard bench for avl_stream_mux3_rr. Per-input queues feed a driver
//   that follows the valid/ready handshake; expected output beats are queued
//   in hand-derived arbitration order and popped by a monitor on each
//   accepted output beat.
module tb_avl_stream_mux3_rr;

    localparam int W = 32;

    typedef struct {
        logic [W-1:0] data;
        logic         sop;
        logic         eop;
        logic [1:0]   empty;
    } beat_t;

    typedef struct {
        beat_t      b;
        logic [1:0] ch;
        logic       b2b;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] in_data  [3];
    logic [1:0]   in_empty [3];
    logic [2:0]   in_valid;
    logic [2:0]   in_sop;
    logic [2:0]   in_eop;
    logic [2:0]   in_ready;
    logic [2:0]   in_af;
    logic         out_ready = 1'b1;
    logic         out_af    = 1'b0;
    logic [W-1:0] out_data;
    logic         out_valid;
    logic         out_sop;
    logic         out_eop;
    logic [1:0]   out_empty;
    logic [1:0]   out_channel;
    logic         sop_err;

    beat_t q0[$];
    beat_t q1[$];
    beat_t q2[$];
    exp_t  sb[$];

    int checks   = 0;
    int errors   = 0;
    int cyc      = 0;
    int last_pop = -10;
    int acc_cnt [3] = '{0, 0, 0};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    avl_stream_mux3_rr #(.WIDTH(W), .MAX_CH(4), .CH_MIN(4)) dut (
        .clk             (clk),
        .rst             (rst),
        .in0_data        (in_data[0]),
        .in0_valid       (in_valid[0]),
        .in0_sop         (in_sop[0]),
        .in0_eop         (in_eop[0]),
        .in0_empty       (in_empty[0]),
        .in0_ready       (in_ready[0]),
        .in0_almost_full (in_af[0]),
        .in1_data        (in_data[1]),
        .in1_valid       (in_valid[1]),
        .in1_sop         (in_sop[1]),
        .in1_eop         (in_eop[1]),
        .in1_empty       (in_empty[1]),
        .in1_ready       (in_ready[1]),
        .in1_almost_full (in_af[1]),
        .in2_data        (in_data[2]),
        .in2_valid       (in_valid[2]),
        .in2_sop         (in_sop[2]),
        .in2_eop         (in_eop[2]),
        .in2_empty       (in_empty[2]),
        .in2_ready       (in_ready[2]),
        .in2_almost_full (in_af[2]),
        .out_data        (out_data),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_sop         (out_sop),
        .out_eop         (out_eop),
        .out_empty       (out_empty),
        .out_channel     (out_channel),
        .out_almost_full (out_af),
        .sop_err         (sop_err)
    );

    function automatic beat_t mk(input int k, input int tag, input int i, input int n);
        beat_t b;
        b.data  = {4'hA, 4'(k), 8'(tag), 16'(i)};
        b.sop   = (i == 0);
        b.eop   = (i == n - 1);
        b.empty = b.eop ? 2'(3 - k) : 2'd0;
        return b;
    endfunction

    task automatic apply(input int k, input bit have, input beat_t b);
        in_valid[k] = have;
        in_data[k]  = have ? b.data : '0;
        in_sop[k]   = have ? b.sop : 1'b0;
        in_eop[k]   = have ? b.eop : 1'b0;
        in_empty[k] = have ? b.empty : 2'd0;
    endtask

    // Input driver: handshake sampled at negedge, next head presented after posedge.
    initial begin
        bit    take [3];
        beat_t h;
        bit    have;
        h = mk(0, 0, 0, 1);
        for (int k = 0; k < 3; k++) apply(k, 1'b0, h);
        forever begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                take[k] = in_valid[k] && in_ready[k];
                if (take[k]) acc_cnt[k] = acc_cnt[k] + 1;
            end
            @(posedge clk);
            #1;
            if (take[0] && q0.size() != 0) void'(q0.pop_front());
            if (take[1] && q1.size() != 0) void'(q1.pop_front());
            if (take[2] && q2.size() != 0) void'(q2.pop_front());
            have = (q0.size() != 0); if (have) h = q0[0]; apply(0, have, h);
            have = (q1.size() != 0); if (have) h = q1[0]; apply(1, have, h);
            have = (q2.size() != 0); if (have) h = q2[0]; apply(2, have, h);
        end
    end

    // Monitor: every accepted output beat is checked against the scoreboard head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (out_valid && out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL extra_beat: got data=%h ch=%0d with nothing expected", out_data, out_channel);
                end else begin
                    e = sb.pop_front();
                    if (out_data !== e.b.data || out_sop !== e.b.sop || out_eop !== e.b.eop ||
                        out_empty !== e.b.empty || out_channel !== e.ch) begin
                        errors++;
                        $display("FAIL beat: got data=%h sop=%0b eop=%0b empty=%0d ch=%0d, exp data=%h sop=%0b eop=%0b empty=%0d ch=%0d",
                                 out_data, out_sop, out_eop, out_empty, out_channel,
                                 e.b.data, e.b.sop, e.b.eop, e.b.empty, e.ch);
                    end
                    if (e.b2b) begin
                        checks++;
                        if (cyc != last_pop + 1) begin
                            errors++;
                            $display("FAIL back_to_back: data=%h at cycle %0d, exp cycle %0d", out_data, cyc, last_pop + 1);
                        end
                    end
                end
                last_pop = cyc;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h exp %h", name, got, exp);
        end
    endtask

    task automatic push_in(input int k, input beat_t b);
        case (k)
            0:       q0.push_back(b);
            1:       q1.push_back(b);
            default: q2.push_back(b);
        endcase
    endtask

    task automatic send(input int k, input int tag, input int n);
        for (int i = 0; i < n; i++) push_in(k, mk(k, tag, i, n));
    endtask

    task automatic expect_beat(input beat_t b, input int k, input bit b2b);
        exp_t e;
        e.b   = b;
        e.ch  = 2'(k);
        e.b2b = b2b;
        sb.push_back(e);
    endtask

    task automatic expect_pkt(input int k, input int tag, input int n, input bit first_b2b, input bit rest_b2b);
        for (int i = 0; i < n; i++) expect_beat(mk(k, tag, i, n), k, (i == 0) ? first_b2b : rest_b2b);
    endtask

    task automatic wait_acc(input int k, input int target);
        int n;
        n = 0;
        while (acc_cnt[k] < target && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        checks++;
        if (acc_cnt[k] < target) begin
            errors++;
            $display("FAIL accept_timeout: in%0d accepted %0d exp %0d", k, acc_cnt[k], target);
        end
    endtask

    task automatic wait_drain(input string name);
        int  n;
        bit  done;
        n    = 0;
        done = 1'b0;
        while (!done && n < 300) begin
            @(negedge clk);
            #1;
            n++;
            done = (q0.size() == 0) && (q1.size() == 0) && (q2.size() == 0) &&
                   (sb.size() == 0) && (in_valid == 3'b000) && !out_valid;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL drain_%s: got %0d beats still expected, exp 0", name, sb.size());
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, exp completion");
        $fatal(1, "watchdog");
    end

    initial begin
        beat_t b;
        int    base;

        // Reset and idle
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_sop_err", 32'(sop_err), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        out_af = 1'b1;
        #1;
        chk("almost_full_hi", 32'(in_af), 32'd7);
        out_af = 1'b0;
        #1;
        chk("almost_full_lo", 32'(in_af), 32'd0);
        @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        chk("idle_out_valid", 32'(out_valid), 32'd0);

        // All inputs streaming 2-beat packets: strict rotation, no bubbles
        @(posedge clk);
        #2;
        send(0, 1, 2); send(0, 2, 2);
        send(1, 1, 2); send(1, 2, 2);
        send(2, 1, 2); send(2, 2, 2);
        expect_pkt(0, 1, 2, 1'b0, 1'b1);
        expect_pkt(1, 1, 2, 1'b1, 1'b1);
        expect_pkt(2, 1, 2, 1'b1, 1'b1);
        expect_pkt(0, 2, 2, 1'b1, 1'b1);
        expect_pkt(1, 2, 2, 1'b1, 1'b1);
        expect_pkt(2, 2, 2, 1'b1, 1'b1);
        wait_drain("rotation");

        // Single 3-beat packet on in1: one-cycle latency, contiguous
        @(posedge clk);
        #2;
        base = acc_cnt[1];
        send(1, 3, 3);
        expect_pkt(1, 3, 3, 1'b0, 1'b1);
        wait_acc(1, base + 1);
        @(negedge clk);
        chk("lat_valid", 32'(out_valid), 32'd1);
        chk("lat_channel", 32'(out_channel), 32'd1);
        chk("lat_sop", 32'(out_sop), 32'd1);
        wait_drain("in1_pkt");
        chk("sop_err_clean", 32'(sop_err), 32'd0);

        // in0 locked while in2 waits; out_ready 1,0,0,1
        @(posedge clk);
        #2;
        base = acc_cnt[0];
        send(0, 4, 3);
        expect_pkt(0, 4, 3, 1'b0, 1'b0);
        wait_acc(0, base + 1);
        @(posedge clk);
        #2;
        send(2, 4, 1);
        expect_pkt(2, 4, 1, 1'b0, 1'b0);
        @(posedge clk);
        #2 out_ready = 1'b0;
        b = mk(0, 4, 1, 3);
        @(negedge clk);
        chk("hold_data_0", out_data, b.data);
        chk("hold_valid_0", 32'(out_valid), 32'd1);
        chk("hold_in2_ready_0", 32'(in_ready[2]), 32'd0);
        @(posedge clk);
        #2 out_ready = 1'b0;
        @(negedge clk);
        chk("hold_data_1", out_data, b.data);
        chk("hold_in2_ready_1", 32'(in_ready[2]), 32'd0);
        @(posedge clk);
        #2 out_ready = 1'b1;
        wait_drain("lock_bp");

        // Packet start without sop on in2
        @(posedge clk);
        #2;
        base    = acc_cnt[2];
        b.data  = 32'hA205_0000;
        b.sop   = 1'b0;
        b.eop   = 1'b1;
        b.empty = 2'd1;
        push_in(2, b);
        expect_beat(b, 2, 1'b0);
        wait_acc(2, base + 1);
        @(negedge clk);
        chk("sop_err_set", 32'(sop_err), 32'd1);
        wait_drain("sop_err");
        chk("sop_err_sticky", 32'(sop_err), 32'd1);

        // Move ptr to 1, then reset in the middle of a 4-beat in0 packet
        @(posedge clk);
        #2;
        send(0, 6, 1);
        expect_pkt(0, 6, 1, 1'b0, 1'b0);
        wait_drain("ptr_move");
        @(posedge clk);
        #2;
        base = acc_cnt[0];
        send(0, 7, 4);
        expect_beat(mk(0, 7, 0, 4), 0, 1'b0);
        expect_beat(mk(0, 7, 1, 4), 0, 1'b1);
        wait_acc(0, base + 2);
        @(posedge clk);
        #2;
        rst = 1'b1;
        q0.delete();
        @(negedge clk);
        chk("midrst_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        chk("postrst_valid", 32'(out_valid), 32'd0);
        chk("postrst_sop_err", 32'(sop_err), 32'd0);
        @(posedge clk);
        #2;
        send(0, 8, 2);
        send(1, 8, 2);
        expect_pkt(0, 8, 2, 1'b0, 1'b1);
        expect_pkt(1, 8, 2, 1'b1, 1'b1);
        wait_drain("postrst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
